buf_audio_rd_ctrl: RTL and testbench

BUF_AUDIO_RD_CTRL -- requirements
Module: buf_audio_rd_ctrl

---
 rtl/buf_audio_pkg.sv | 20 ++
 rtl/audio_rd_watchdog.sv | 36 +++
 rtl/buf_audio_rd_ctrl.sv | 150 +++++++++++++++
 tb/tb_buf_audio_rd_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_audio_pkg.sv
// Shared types and constants for the audio buffer read controller.
// Holds the FSM state encoding, default frame geometry and the channel-index width helper.
package buf_audio_pkg;

  localparam int DEF_AUDIO_WIDTH        = 24;
  localparam int DEF_NUM_AUDIO_CHANNELS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STREAM  = 3'd4
  } rd_state_e;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_rd_watchdog.sv
// Stall counter: counts consecutive stalled beats, flags expiry on the TIMEOUT_CYCLES-th one.
// Zero-latency expiry flag; clear_i has priority over counting.
module audio_rd_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = stall_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buf_audio_rd_ctrl.sv
// Pops one frame from the audio buffer and streams its channel words over a valid/ready port.
// Optional STREAM stall watchdog enabled by macro BUF_AUDIO_RD_TIMEOUT_EN.
module buf_audio_rd_ctrl
  import buf_audio_pkg::*;
#(
  parameter int NUM_AUDIO_CHANNELS = DEF_NUM_AUDIO_CHANNELS,
  parameter int AUDIO_WIDTH        = DEF_AUDIO_WIDTH,
  parameter int READ_LATENCY       = 1,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                      sys_clk,
  input  logic                                      sys_rst,
  input  logic                                      enable,
  input  logic                                      buffer_ready,
  input  logic                                      buffer_full,
  input  logic [NUM_AUDIO_CHANNELS*AUDIO_WIDTH-1:0] audio_channel_in,
  output logic                                      adv_read_enable,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [AUDIO_WIDTH-1:0]                    m_data,
  output logic [chan_idx_w(NUM_AUDIO_CHANNELS)-1:0] m_chan,
  output logic                                      m_last,
  output logic                                      overrun,
  output logic [15:0]                               frame_count,
  output logic                                      timeout_err
);

  localparam int               CW        = chan_idx_w(NUM_AUDIO_CHANNELS);
  localparam logic [CW-1:0]    LAST_CH   = CW'(NUM_AUDIO_CHANNELS - 1);
  localparam logic [1:0]       WAIT_LAST = 2'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

  if (NUM_AUDIO_CHANNELS < 2) begin : g_bad_nch
    $error("NUM_AUDIO_CHANNELS must be >= 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  rd_state_e              state_q, state_d;
  logic [1:0]             wait_q, wait_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic [AUDIO_WIDTH-1:0] frame_q [NUM_AUDIO_CHANNELS];
  logic                   overrun_q;
  logic [15:0]            frame_cnt_q;
  logic                   beat_hs, last_hs, expired;

  assign m_valid         = (state_q == ST_STREAM);
  assign beat_hs         = m_valid && m_ready;
  assign last_hs         = beat_hs && (chan_q == LAST_CH);
  assign adv_read_enable = (state_q == ST_POP);
  assign m_data          = m_valid ? frame_q[chan_q] : '0;
  assign m_chan          = chan_q;
  assign m_last          = m_valid && (chan_q == LAST_CH);
  assign overrun         = overrun_q;
  assign frame_count     = frame_cnt_q;

`ifdef BUF_AUDIO_RD_TIMEOUT_EN
  logic timeout_q;

  audio_rd_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .stall_i   (m_valid && !m_ready),
    .clear_i   (beat_hs || (state_q != ST_STREAM)),
    .expired_o (expired)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      timeout_q <= 1'b0;
    end else if (expired) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && buffer_ready) state_d = ST_POP;
      end
      ST_POP: begin
        wait_d  = '0;
        state_d = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + 2'd1;
      end
      ST_CAPTURE: begin
        chan_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // A stalled beat cannot also be a handshake, so expiry needs no priority over it.
        if (expired) begin
          chan_d  = '0;
          state_d = ST_IDLE;
        end else if (beat_hs) begin
          if (chan_q == LAST_CH) begin
            chan_d  = '0;
            state_d = (enable && buffer_ready) ? ST_POP : ST_IDLE;
          end else begin
            chan_d = chan_q + CW'(1);
          end
        end
      end
      default: begin
        chan_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      chan_q      <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < NUM_AUDIO_CHANNELS; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      chan_q  <= chan_d;
      if (buffer_full && (state_q == ST_IDLE || state_q == ST_STREAM)) overrun_q <= 1'b1;
      if (last_hs) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == ST_CAPTURE) begin
        for (int i = 0; i < NUM_AUDIO_CHANNELS; i++) begin
          frame_q[i] <= audio_channel_in[i*AUDIO_WIDTH +: AUDIO_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_buf_audio_rd_ctrl.sv
// Directed bench for buf_audio_rd_ctrl: idle, single frame, backpressure, back-to-back,
// enable drop mid-frame, overrun/reset and stall watchdog (macro-dependent).
module tb_buf_audio_rd_ctrl;

  localparam int N  = 8;
  localparam int W  = 24;
  localparam int CW = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           enable;
  logic           buffer_ready;
  logic           buffer_full;
  logic [N*W-1:0] audio_channel_in;
  logic           adv_read_enable;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic [CW-1:0]  m_chan;
  logic           m_last;
  logic           overrun;
  logic [15:0]    frame_count;
  logic           timeout_err;

  int n_vec = 0;
  int n_err = 0;

  buf_audio_rd_ctrl #(
    .NUM_AUDIO_CHANNELS (N),
    .AUDIO_WIDTH        (W),
    .READ_LATENCY       (1),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .enable           (enable),
    .buffer_ready     (buffer_ready),
    .buffer_full      (buffer_full),
    .audio_channel_in (audio_channel_in),
    .adv_read_enable  (adv_read_enable),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_chan           (m_chan),
    .m_last           (m_last),
    .overrun          (overrun),
    .frame_count      (frame_count),
    .timeout_err      (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] frame_pat(input logic [W-1:0] base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(i);
    return v;
  endfunction

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!m_valid && c < 50) begin
      tick();
      c++;
    end
    chk("wait_valid", 32'(m_valid), 32'd1);
  endtask

  // Streams nframes, checking every observed beat; one stall window of stall_len cycles on stall_beat.
  task automatic stream_frames(input int nframes, input bit hold_ready,
                               input int stall_beat, input int stall_len);
    int beat = 0, done = 0, pops = 0, adj = 0, stalls = 0, cyc = 0;
    bit prev_adv = 1'b0, want_pop = 1'b0;
    while (done < nframes && cyc < 500) begin
      tick();
      cyc++;
      if (want_pop) begin
        chk("pop_after_last", 32'(adv_read_enable), 32'd1);
        want_pop = 1'b0;
      end
      if (adv_read_enable) begin
        pops++;
        if (prev_adv) adj++;
        if (!hold_ready) buffer_ready = 1'b0;
      end
      prev_adv = adv_read_enable;
      if (m_valid) begin
        chk("m_data", 32'(m_data), 32'h100000 + 32'(beat));
        chk("m_chan", 32'(m_chan), 32'(beat));
        chk("m_last", 32'(m_last), 32'(beat == N - 1));
        if (beat == 0) audio_channel_in = frame_pat(24'hABC000);
        if (beat == stall_beat && stalls < stall_len) begin
          m_ready = 1'b0;
          stalls++;
        end else begin
          m_ready = 1'b1;
          beat++;
          if (beat == N) begin
            beat = 0;
            done++;
            audio_channel_in = frame_pat(24'h100000);
            if (done == nframes) buffer_ready = 1'b0;
            else if (hold_ready) want_pop = 1'b1;
          end
        end
      end else begin
        m_ready = 1'b1;
      end
    end
    chk("frames_done", 32'(done), 32'(nframes));
    chk("pop_count", 32'(pops), 32'(nframes));
    chk("adjacent_pops", 32'(adj), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(stall_len));
    tick();
  endtask

  initial begin
    int adv_seen;
    int beats;
    sys_rst          = 1'b1;
    enable           = 1'b1;
    buffer_ready     = 1'b0;
    buffer_full      = 1'b0;
    m_ready          = 1'b1;
    audio_channel_in = frame_pat(24'h100000);

    // Reset then idle with no data available
    do_reset();
    adv_seen = 0;
    repeat (20) begin
      tick();
      if (adv_read_enable) adv_seen++;
    end
    chk("idle_adv", 32'(adv_seen), 32'd0);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_m_data", 32'(m_data), 32'd0);
    chk("idle_m_chan", 32'(m_chan), 32'd0);
    chk("idle_m_last", 32'(m_last), 32'd0);
    chk("idle_overrun", 32'(overrun), 32'd0);
    chk("idle_frame_count", 32'(frame_count), 32'd0);
    chk("idle_timeout", 32'(timeout_err), 32'd0);

    // Single frame, no backpressure
    buffer_ready = 1'b1;
    stream_frames(1, 1'b0, -1, 0);
    chk("single_frame_count", 32'(frame_count), 32'd1);

    // Backpressure on beat 3 for 5 cycles
    do_reset();
    buffer_ready = 1'b1;
    stream_frames(1, 1'b0, 3, 5);
    chk("bp_frame_count", 32'(frame_count), 32'd1);

    // Back-to-back frames with buffer_ready held
    do_reset();
    buffer_ready = 1'b1;
    stream_frames(3, 1'b1, -1, 0);
    chk("b2b_frame_count", 32'(frame_count), 32'd3);
    chk("b2b_idle_after", 32'(adv_read_enable), 32'd0);

    // Dropping enable mid-frame finishes the frame but blocks the next pop
    buffer_ready = 1'b1;
    wait_valid();
    enable   = 1'b0;
    adv_seen = 0;
    beats    = 0;
    repeat (20) begin
      if (m_valid && m_ready) beats++;
      tick();
      if (adv_read_enable) adv_seen++;
    end
    chk("en_drop_beats", 32'(beats), 32'(N));
    chk("en_drop_pops", 32'(adv_seen), 32'd0);
    chk("en_drop_frame_count", 32'(frame_count), 32'd4);

    // Overrun during STREAM, then reset mid-frame
    enable = 1'b1;
    wait_valid();
    buffer_ready = 1'b0;
    m_ready      = 1'b0;
    chk("ovr_before", 32'(overrun), 32'd0);
    buffer_full = 1'b1;
    tick();
    buffer_full = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_frame_count", 32'(frame_count), 32'd4);
    sys_rst = 1'b1;
    tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_m_chan", 32'(m_chan), 32'd0);
    sys_rst = 1'b0;
    m_ready = 1'b1;
    beats   = 0;
    repeat (5) begin
      tick();
      if (m_valid) beats++;
    end
    chk("rst_discard", 32'(beats), 32'd0);

    // Stall watchdog
    buffer_ready = 1'b1;
    wait_valid();
    buffer_ready = 1'b0;
    m_ready      = 1'b0;
    repeat (15) tick();
`ifdef BUF_AUDIO_RD_TIMEOUT_EN
    chk("wd_pre_valid", 32'(m_valid), 32'd1);
    chk("wd_pre_timeout", 32'(timeout_err), 32'd0);
    tick();
    chk("wd_timeout", 32'(timeout_err), 32'd1);
    chk("wd_abandon", 32'(m_valid), 32'd0);
    chk("wd_frame_count", 32'(frame_count), 32'd0);
    tick();
    chk("wd_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (25) tick();
    chk("nowd_valid", 32'(m_valid), 32'd1);
    chk("nowd_timeout", 32'(timeout_err), 32'd0);
    chk("nowd_data", 32'(m_data), 32'h100000);
    chk("nowd_frame_count", 32'(frame_count), 32'd0);
`endif
    m_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
